vram_sync_sequencer: RTL and testbench
======================================

VRAM_SYNC_SEQUENCER -- requirements
Module: vram_sync_sequencer

Interface
REQ-001 SHALL use one clock domain; reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port sync_req, input, 1 bit: one-cycle pulse that starts a full copy (frame-sync event).
REQ-005 SHALL have port halt, input, 1 bit: destination back-pressure; while high, no destination write occurs and the pipeline freezes.
REQ-006 SHALL have port vram_addr_b, output, 11 bits: shared port-B read address to all four CPU-facing RAMs; tile uses [9:0], pattern [10:0], palette [7:0], sprite [4:0].
REQ-007 SHALL have port vram_wren_b, output, 1 bit: port-B write enable to all four RAMs; constant 0.
REQ-008 SHALL have ports tilram_rddata_b, patram_rddata_b, palram_rddata_b, sprram_rddata_b, each input, 128 bits: port-B read data, one-cycle registered latency.
REQ-009 SHALL have port dst_sel, output, 2 bits: destination RAM (0 tile, 1 pattern, 2 palette, 3 sprite).
REQ-010 SHALL have port dst_addr, output, 11 bits: destination word address, zero-extended.
REQ-011 SHALL have port dst_wrdata, output, 128 bits: destination write data.
REQ-012 SHALL have port dst_wren, output, 1 bit: destination write strobe, one word per high cycle.
REQ-013 SHALL have port busy, output, 1 bit: copy in progress; used to lock out CPU port-A writes.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a copy completes.

Function
REQ-015 SHALL implement the states IDLE, TIL, PAT, PAL, SPR and DONE.
REQ-016 SHALL, in IDLE, transition to TIL on the cycle after sync_req=1 is sampled; sync_req is ignored in every other state.
REQ-017 SHALL, in each copy state, issue read addresses 0..N-1 from an 11-bit counter: N=1024 (TIL), 2048 (PAT), 256 (PAL), 32 (SPR).
REQ-018 SHALL, after issuing address N-1, clear the counter and enter the next state (TIL->PAT->PAL->SPR->DONE) with no idle cycle between RAMs.
REQ-019 SHALL register each issued read as a pipeline entry of valid, sel and addr; on the following cycle dst_wren=valid_q, dst_sel=sel_q, dst_addr=addr_q, and dst_wrdata = the rddata of the RAM selected by sel_q.
REQ-020 SHALL freeze the counter, state and pipeline entry while halt=1, and drive dst_wren=0.
REQ-021 SHALL drive vram_addr_b=addr_q while halt=1 with valid_q=1, so the RAM re-reads the in-flight word; otherwise vram_addr_b = the counter value.
REQ-022 SHALL complete the stalled write on the first cycle with halt=0, with no word lost or duplicated.
REQ-023 SHALL hold DONE for exactly one cycle with done=1, then return to IDLE.
REQ-024 SHALL enter DONE only after the final sprite write (sprite addr 31) has been performed.
REQ-025 SHALL drive busy=1 in TIL, PAT, PAL and SPR, and busy=0 in IDLE and DONE.
REQ-026 SHALL, with halt held at 0, produce exactly 3360 writes: first dst_wren one cycle after TIL entry, last write at cycle 3361 after sync_req, done at cycle 3362.
REQ-027 SHALL ignore a sync_req that coincides with the DONE cycle.
REQ-028 SHALL, in IDLE and DONE, drive vram_addr_b=0 and dst_wren=0.
REQ-029 SHALL never assert vram_wren_b.

Reset
REQ-030 SHALL, on rst=1, enter IDLE and clear the counter, valid_q, sel_q and addr_q.
REQ-031 SHALL, in the cycle after reset, drive busy=0, done=0, dst_wren=0, dst_sel=0, dst_addr=0 and vram_addr_b=0.
REQ-032 SHALL, on reset mid-copy, abandon the copy without a done pulse; a new sync_req then restarts the copy at tile address 0.
REQ-033 SHALL give reset priority over sync_req and halt.

Verification
REQ-034 SHALL cover: sync_req pulse at cycle 0, halt=0 -> 3360 writes in order (tile 0..1023, pattern 0..2047, palette 0..255, sprite 0..31) with dst_wrdata matching the model memories, done only at cycle 3362, busy high cycles 1..3361.
REQ-035 SHALL cover: halt=1 for 5 cycles at pattern address 100 -> dst_wren low for 5 cycles, vram_addr_b=100 throughout, then pattern 100 written exactly once and pattern 101 written next; done delayed by 5 cycles.
REQ-036 SHALL cover: sync_req pulsed again at tile address 500 and during DONE -> no restart and no extra writes; total remains 3360.
REQ-037 SHALL cover: rst at palette address 10 -> next cycle busy=0 and dst_wren=0, no done pulse; a following sync_req gives a first write of tile 0.
REQ-038 SHALL cover: halt toggling every cycle for the whole copy -> 3360 writes with no duplicates or gaps, and vram_wren_b=0 throughout.
REQ-039 SHALL cover: sync_req asserted in the same cycle as rst -> the block stays in IDLE with busy=0.

Source files
------------

// File: rtl/vram_sync_sequencer_if.sv
// Port bundle between the frame-sync VRAM copy sequencer and its RAMs/destination.
// master = environment side (drives requests and read data), slave = sequencer side.
interface vram_sync_sequencer_if;
  logic         sync_req;
  logic         halt;
  logic [10:0]  vram_addr_b;
  logic         vram_wren_b;
  logic [127:0] tilram_rddata_b;
  logic [127:0] patram_rddata_b;
  logic [127:0] palram_rddata_b;
  logic [127:0] sprram_rddata_b;
  logic [1:0]   dst_sel;
  logic [10:0]  dst_addr;
  logic [127:0] dst_wrdata;
  logic         dst_wren;
  logic         busy;
  logic         done;

  modport master (
    output sync_req, halt,
    output tilram_rddata_b, patram_rddata_b, palram_rddata_b, sprram_rddata_b,
    input  vram_addr_b, vram_wren_b,
    input  dst_sel, dst_addr, dst_wrdata, dst_wren, busy, done
  );

  modport slave (
    input  sync_req, halt,
    input  tilram_rddata_b, patram_rddata_b, palram_rddata_b, sprram_rddata_b,
    output vram_addr_b, vram_wren_b,
    output dst_sel, dst_addr, dst_wrdata, dst_wren, busy, done
  );
endinterface

// File: rtl/vram_sync_sequencer.sv
// Copies the tile, pattern, palette and sprite RAMs to the destination on each
// frame-sync request, one 128-bit word per cycle, with halt back-pressure.
module vram_sync_sequencer (
  input  logic                  clk,
  input  logic                  rst,
  vram_sync_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, TIL, PAT, PAL, SPR, DONE} state_t;

  state_t      state_reg, state_next;
  logic [10:0] cnt_reg, cnt_next;
  logic        valid_reg, valid_next;
  logic [1:0]  sel_reg, sel_next;
  logic [10:0] addr_reg, addr_next;

  logic        copying;
  logic        issue;
  logic [10:0] last_addr;
  logic [1:0]  cur_sel;
  state_t      following;

  always_comb begin
    copying   = 1'b0;
    last_addr = 11'd0;
    cur_sel   = 2'd0;
    following = IDLE;
    case (state_reg)
      TIL: begin copying = 1'b1; last_addr = 11'd1023; cur_sel = 2'd0; following = PAT;  end
      PAT: begin copying = 1'b1; last_addr = 11'd2047; cur_sel = 2'd1; following = PAL;  end
      PAL: begin copying = 1'b1; last_addr = 11'd255;  cur_sel = 2'd2; following = SPR;  end
      SPR: begin copying = 1'b1; last_addr = 11'd31;   cur_sel = 2'd3; following = DONE; end
      default: ;
    endcase
  end

  // SPR parks the counter at 32 for one drain cycle so DONE follows the last write.
  assign issue = copying && !(state_reg == SPR && cnt_reg == 11'd32);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    valid_next = valid_reg;
    sel_next   = sel_reg;
    addr_next  = addr_reg;
    case (state_reg)
      IDLE: begin
        cnt_next   = 11'd0;
        valid_next = 1'b0;
        sel_next   = 2'd0;
        addr_next  = 11'd0;
        if (bus.sync_req)
          state_next = TIL;
      end
      DONE: begin
        cnt_next   = 11'd0;
        valid_next = 1'b0;
        sel_next   = 2'd0;
        addr_next  = 11'd0;
        state_next = IDLE;
      end
      default: begin
        // Back-pressure only freezes the copy states; DONE always lasts one cycle.
        if (!bus.halt) begin
          valid_next = issue;
          sel_next   = issue ? cur_sel : 2'd0;
          addr_next  = issue ? cnt_reg : 11'd0;
          if (!issue) begin
            state_next = DONE;
            cnt_next   = 11'd0;
          end else if (cnt_reg == last_addr) begin
            if (state_reg == SPR) begin
              cnt_next = cnt_reg + 11'd1;
            end else begin
              cnt_next   = 11'd0;
              state_next = following;
            end
          end else begin
            cnt_next = cnt_reg + 11'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 11'd0;
      valid_reg <= 1'b0;
      sel_reg   <= 2'd0;
      addr_reg  <= 11'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      valid_reg <= valid_next;
      sel_reg   <= sel_next;
      addr_reg  <= addr_next;
    end
  end

  // While stalled, re-read the in-flight word so its data is fresh on release.
  always_comb begin
    if (!copying)
      bus.vram_addr_b = 11'd0;
    else if (bus.halt && valid_reg)
      bus.vram_addr_b = addr_reg;
    else
      bus.vram_addr_b = cnt_reg;
  end

  always_comb begin
    case (sel_reg)
      2'd0:    bus.dst_wrdata = bus.tilram_rddata_b;
      2'd1:    bus.dst_wrdata = bus.patram_rddata_b;
      2'd2:    bus.dst_wrdata = bus.palram_rddata_b;
      default: bus.dst_wrdata = bus.sprram_rddata_b;
    endcase
  end

  assign bus.vram_wren_b = 1'b0;
  assign bus.dst_wren    = valid_reg && !bus.halt;
  assign bus.dst_sel     = sel_reg;
  assign bus.dst_addr    = addr_reg;
  assign bus.busy        = copying;
  assign bus.done        = (state_reg == DONE);

endmodule

// File: tb/tb_vram_sync_sequencer.sv
// Self-checking bench: scenario table of full copies against an ordered write-list
// model, plus hand-written reset sequences.
module tb_vram_sync_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vram_sync_sequencer_if bus ();

  vram_sync_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  logic [127:0] til_mem [1024];
  logic [127:0] pat_mem [2048];
  logic [127:0] pal_mem [256];
  logic [127:0] spr_mem [32];

  // Source RAM port B: one-cycle registered read.
  always @(posedge clk) begin
    bus.tilram_rddata_b <= til_mem[bus.vram_addr_b[9:0]];
    bus.patram_rddata_b <= pat_mem[bus.vram_addr_b[10:0]];
    bus.palram_rddata_b <= pal_mem[bus.vram_addr_b[7:0]];
    bus.sprram_rddata_b <= spr_mem[bus.vram_addr_b[4:0]];
  end

  int checks   = 0;
  int failures = 0;

  function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [127:0] exp_data(logic [1:0] s, logic [10:0] a);
    case (s)
      2'd0:    return til_mem[a[9:0]];
      2'd1:    return pat_mem[a];
      2'd2:    return pal_mem[a[7:0]];
      default: return spr_mem[a[4:0]];
    endcase
  endfunction

  typedef struct { logic [1:0] sel; logic [10:0] addr; } wr_t;
  wr_t exp_q[$];

  typedef struct {
    string name;
    int    mode;       // 0 plain, 1 halt 5 at pattern 100, 2 resync, 3 halt toggle, 4 random halt
    int    exp_writes;
    int    exp_delay;  // done delay past cycle 3362; -1 = one cycle per halted busy cycle
  } vec_t;
  vec_t vecs[5];

  localparam int BASE_DONE = 3362;

  task automatic run_copy(input int mode, output int writes, output int done_cyc, output int hcount);
    int sizes[4] = '{1024, 2048, 256, 32};
    wr_t e;
    logic busy_exp, done_exp;
    exp_q.delete();
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < sizes[s]; a++)
        exp_q.push_back('{2'(s), 11'(a)});
    writes = 0; done_cyc = -1; hcount = 0;
    @(posedge clk); #1;
    bus.sync_req = 1'b1;
    bus.halt     = 1'b0;
    for (int cyc = 1; cyc < 9000; cyc++) begin
      @(posedge clk); #1;
      bus.sync_req = (mode == 2) && (cyc == 501 || cyc == BASE_DONE + hcount);
      case (mode)
        1:       bus.halt = (cyc >= 1126 && cyc <= 1130);
        3:       bus.halt = cyc[0];
        4:       bus.halt = ($urandom_range(0, 3) == 0);
        default: bus.halt = 1'b0;
      endcase
      @(negedge clk);
      busy_exp = (cyc < BASE_DONE + hcount);
      done_exp = (cyc == BASE_DONE + hcount);
      chk("vram_wren_b", bus.vram_wren_b, 0);
      chk("busy", bus.busy, busy_exp);
      chk("done", bus.done, done_exp);
      if (bus.done) done_cyc = cyc;
      if (bus.halt && busy_exp) chk("halt_wren", bus.dst_wren, 0);
      if (mode == 1 && bus.halt) chk("halt_addr_b", bus.vram_addr_b, 100);
      if (bus.dst_wren) begin
        if (exp_q.size() == 0) begin
          chk("extra_write", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("dst_sel", bus.dst_sel, e.sel);
          chk("dst_addr", bus.dst_addr, e.addr);
          chk("dst_wrdata", bus.dst_wrdata, exp_data(e.sel, e.addr));
        end
        writes++;
      end
      if (bus.halt && busy_exp) hcount++;
      if (cyc >= BASE_DONE + hcount + 3) break;
    end
    bus.sync_req = 1'b0;
    bus.halt     = 1'b0;
  endtask

  initial begin
    int writes, done_cyc, hcount, exp_done;
    bus.sync_req = 1'b0;
    bus.halt     = 1'b0;
    foreach (til_mem[i]) til_mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    foreach (pat_mem[i]) pat_mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    foreach (pal_mem[i]) pal_mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    foreach (spr_mem[i]) spr_mem[i] = {$urandom(), $urandom(), $urandom(), $urandom()};

    vecs[0] = '{"plain",        0, 3360,  0};
    vecs[1] = '{"halt5_pat100", 1, 3360,  5};
    vecs[2] = '{"resync",       2, 3360,  0};
    vecs[3] = '{"halt_toggle",  3, 3360, -1};
    vecs[4] = '{"halt_random",  4, 3360, -1};

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_wren", bus.dst_wren, 0);
    chk("rst_sel", bus.dst_sel, 0);
    chk("rst_addr", bus.dst_addr, 0);
    chk("rst_addr_b", bus.vram_addr_b, 0);

    foreach (vecs[v]) begin
      run_copy(vecs[v].mode, writes, done_cyc, hcount);
      exp_done = BASE_DONE + ((vecs[v].exp_delay >= 0) ? vecs[v].exp_delay : hcount);
      chk({vecs[v].name, "_writes"}, writes, vecs[v].exp_writes);
      chk({vecs[v].name, "_done_cycle"}, done_cyc, exp_done);
      chk({vecs[v].name, "_left"}, exp_q.size(), 0);
      $display("copy %s: writes=%0d done_cycle=%0d halted=%0d", vecs[v].name, writes, done_cyc, hcount);
    end

    // Reset in the middle of the palette copy (palette 10 issued at cycle 3083)
    @(posedge clk); #1 bus.sync_req = 1'b1;
    for (int cyc = 1; cyc <= 3083; cyc++) begin
      @(posedge clk); #1 bus.sync_req = 1'b0;
    end
    @(negedge clk);
    chk("midrst_addr_b", bus.vram_addr_b, 10);
    chk("midrst_sel", bus.dst_sel, 2);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_wren", bus.dst_wren, 0);
    chk("midrst_done", bus.done, 0);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_done", bus.done, 0);
    end
    @(posedge clk); #1 bus.sync_req = 1'b1;
    @(posedge clk); #1 bus.sync_req = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("restart_wren", bus.dst_wren, 1);
    chk("restart_sel", bus.dst_sel, 0);
    chk("restart_addr", bus.dst_addr, 0);
    chk("restart_data", bus.dst_wrdata, til_mem[0]);
    $display("reset mid-copy: restart first write sel=%0d addr=%0d", bus.dst_sel, bus.dst_addr);

    // sync_req coinciding with reset is ignored
    @(posedge clk); #1 begin rst = 1'b1; bus.sync_req = 1'b1; end
    @(posedge clk); #1 begin rst = 1'b0; bus.sync_req = 1'b0; end
    repeat (3) begin
      @(negedge clk);
      chk("syncrst_busy", bus.busy, 0);
      chk("syncrst_wren", bus.dst_wren, 0);
    end
    $display("sync_req with rst: busy=%0d", bus.busy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
